adc_axi_lite_slave: RTL
=======================

Name: adc_axi_lite_slave

Overview:
AXI4-Lite slave register file that answers the master transactions issued toward the ADC interface IP's S00_AXI port. It holds four 32-bit read/write configuration registers, exports them to the ADC datapath, and exposes read-only ADC sample and sample-count registers. It sits between the AXI interconnect (or master VIP) and the ADC capture logic.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width; only 32 supported.
C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 word registers.
C_ADC_WIDTH, 12, ADC sample width, must be 1..32.

Ports:
ACLK  in  1  clock
ARESETN  in  1  asynchronous active-low reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID/S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte strobes
S_AXI_WVALID/S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  always 2'b00 OKAY
S_AXI_BVALID/S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID/S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always 2'b00 OKAY
S_AXI_RVALID/S_AXI_RREADY  out/in  1  R handshake
adc_valid  in  1  sample strobe
adc_data  in  C_ADC_WIDTH  ADC sample
cfg_reg0..cfg_reg3  out  32 each  register contents to datapath

Behaviour:
- Reset (ARESETN low, async): all READY/VALID low, RDATA 0, regs 0..3 = 0, sample = 0, count = 0. Reset mid-transaction aborts it; nothing is committed.
- Register map (word index = ADDR[4:2]; ADDR[1:0] ignored): 0..3 RW; 4 sample RO (zero-extended adc_data); 5 count RO; 6,7 reserved, read 0. Writes to 4..7 are accepted with OKAY and have no effect.
- Write FSM (W_IDLE, W_RESP):
  - AWREADY is asserted for one cycle when AWVALID is high, no address is latched, and state is W_IDLE. WREADY follows the same rule for W. AW and W are latched independently, in either order or in the same cycle.
  - Once both are latched: in that cycle, apply WSTRB byte-wise to the target register, clear both latches, go to W_RESP, and assert BVALID on the next edge.
  - BVALID holds until BREADY is high; then return to W_IDLE. No new AW/W is accepted while in W_RESP.
  - Throughput: one write per 3 cycles at best.
- Read FSM (R_IDLE, R_DATA):
  - In R_IDLE with ARVALID high: ARREADY pulses for one cycle, RDATA is registered from the addressed register, and RVALID rises on the next edge.
  - RDATA and RVALID hold until RREADY is high; then return to R_IDLE.
  - Latency is ARVALID to RVALID = 2 edges.
- Read/write in the same cycle to the same register: the read returns the pre-write value.
- Capture:
  - When cfg_reg0[0] = 1 and adc_valid is high, latch the sample and increment the count (32-bit, wraps 0xFFFFFFFF -> 0).
  - Writing cfg_reg0[1] = 1 clears the count. Bit 1 reads back 0 (self-clearing, not stored).
  - If a clear and adc_valid coincide, the clear wins (count = 0) and the sample is still latched.
- cfg_reg outputs are driven directly from the flops; an update is visible the cycle after the write commits.

Decomposition:
- Package adc_axi_pkg: AXI_RESP_OKAY, register index constants (REG_CFG0..REG_COUNT), the wr_state_t and rd_state_t enums, and CTRL_EN_BIT = 0 / CTRL_CLR_BIT = 1.
- One sub-module, adc_sample_capture: sample register plus counter, with en/clr/valid inputs. The AXI FSMs stay in the top module.

Test Plan:
1. Write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC, then read all four back -> 1,2,3,4, RRESP = BRESP = 0, and cfg_reg0..3 match.
2. W presented 3 cycles before AW (and, separately, the reverse order) -> exactly one write commits; BVALID rises one edge after the second handshake.
3. Write 0xAABBCCDD with WSTRB = 4'b0101 over reg1 = 0x11223344 -> readback 0x11BB33DD.
4. Hold BREADY and RREADY low for 5 cycles -> BVALID/RVALID and RDATA stay stable; a second AWVALID gets no AWREADY until B completes.
5. Write reg0 = 0x1, drive 3 adc_valid pulses with data 0xABC -> reg4 = 0xABC, reg5 = 3. Write reg0 = 0x3 coinciding with adc_valid -> reg5 = 0 and reg0 reads 0x1.
6. Deassert ARESETN while RVALID is pending -> RVALID and BVALID drop immediately and all registers read 0 after release; read of 0x18 -> 0 with OKAY.

Source files
------------

// File: rtl/adc_axi_pkg.sv
// ----------------------------------------------------------------------------
// adc_axi_pkg
// Shared definitions for the ADC AXI4-Lite register slave: response code,
// register word indices, control-bit positions, FSM state types and a
// byte-strobe merge helper.
// ----------------------------------------------------------------------------
package adc_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

  // Word index = byte address [4:2]
  localparam logic [2:0] REG_CFG0   = 3'd0;
  localparam logic [2:0] REG_CFG1   = 3'd1;
  localparam logic [2:0] REG_CFG2   = 3'd2;
  localparam logic [2:0] REG_CFG3   = 3'd3;
  localparam logic [2:0] REG_SAMPLE = 3'd4;
  localparam logic [2:0] REG_COUNT  = 3'd5;

  // Control bits inside cfg register 0
  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  typedef enum logic {W_IDLE, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  // Replace the byte lanes of old_val selected by strb with those of new_val.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/adc_sample_capture.sv
// ----------------------------------------------------------------------------
// adc_sample_capture
// Holds the most recent ADC sample and a 32-bit count of captured samples.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   i_en            capture enable (cfg register 0, bit 0)
//   i_clr           one-cycle count clear; wins over a coincident increment
//   i_valid/i_data  ADC sample strobe and sample value
//   o_sample        zero-extended last captured sample
//   o_count         number of captured samples, wraps at 2^32
// ----------------------------------------------------------------------------
module adc_sample_capture
  import adc_axi_pkg::*;
#(
  parameter int ADC_WIDTH = 12
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic                 i_clr,
  input  logic                 i_valid,
  input  logic [ADC_WIDTH-1:0] i_data,
  output logic [31:0]          o_sample,
  output logic [31:0]          o_count
);

  logic [ADC_WIDTH-1:0] r_sample;
  logic [31:0]          r_count;
  logic                 w_capture;

  assign w_capture = i_en && i_valid;

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sample <= '0;
      r_count  <= '0;
    end else begin
      if (w_capture) r_sample <= i_data;
      // A clear landing with a sample still latches the sample; only the
      // count is forced to zero.
      if (i_clr)          r_count <= '0;
      else if (w_capture) r_count <= r_count + 32'd1;
    end
  end

  assign o_sample = 32'(r_sample);
  assign o_count  = r_count;

endmodule

// File: rtl/adc_axi_lite_slave.sv
// ----------------------------------------------------------------------------
// adc_axi_lite_slave
// AXI4-Lite slave for the ADC interface IP. Four RW config registers driven
// straight to the datapath, plus read-only sample (4) and count (5) words;
// words 6/7 read zero. Writes to 4..7 complete with OKAY and do nothing.
// Ports:
//   ACLK, ARESETN          clock, asynchronous active-low reset
//   S_AXI_AW*/W*/B*        write address, data and response channels
//   S_AXI_AR*/R*           read address and data channels
//   adc_valid, adc_data    ADC sample strobe and value
//   cfg_reg0..cfg_reg3     config register contents
// ----------------------------------------------------------------------------
module adc_axi_lite_slave
  import adc_axi_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5,
  parameter int C_ADC_WIDTH        = 12
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            adc_valid,
  input  logic [C_ADC_WIDTH-1:0]          adc_data,
  output logic [31:0]                     cfg_reg0,
  output logic [31:0]                     cfg_reg1,
  output logic [31:0]                     cfg_reg2,
  output logic [31:0]                     cfg_reg3
);

  // ---------------- write channel ----------------
  wr_state_t                           r_wr_state, w_wr_state_next;
  logic                                r_aw_latched, r_w_latched;
  logic [2:0]                          r_aw_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0]       r_wdata;
  logic [C_S_AXI_DATA_WIDTH/8-1:0]     r_wstrb;
  logic                                w_aw_hs, w_w_hs, w_commit, w_clr;
  logic [31:0]                         r_cfg [4];
  logic [31:0]                         w_cfg_next;

  // Readies are combinational so a handshake completes in the cycle VALID is
  // seen; they are gated by ARESETN so nothing is accepted while in reset.
  assign S_AXI_AWREADY = ARESETN && S_AXI_AWVALID && !r_aw_latched && (r_wr_state == W_IDLE);
  assign S_AXI_WREADY  = ARESETN && S_AXI_WVALID  && !r_w_latched  && (r_wr_state == W_IDLE);
  assign w_aw_hs       = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_w_hs        = S_AXI_WVALID  && S_AXI_WREADY;
  assign w_commit      = r_aw_latched && r_w_latched;
  assign w_clr         = w_commit && (r_aw_idx == REG_CFG0) && r_wstrb[0] && r_wdata[CTRL_CLR_BIT];

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_aw_latched <= 1'b0;
      r_w_latched  <= 1'b0;
      r_aw_idx     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
    end else if (w_commit) begin
      r_aw_latched <= 1'b0;
      r_w_latched  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_latched <= 1'b1;
        r_aw_idx     <= S_AXI_AWADDR[4:2];
      end
      if (w_w_hs) begin
        r_w_latched <= 1'b1;
        r_wdata     <= S_AXI_WDATA;
        r_wstrb     <= S_AXI_WSTRB;
      end
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_wr_state <= W_IDLE;
    else          r_wr_state <= w_wr_state_next;
  end

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_wr_state_next = r_wr_state;
    case (r_wr_state)
      W_IDLE: if (w_commit)     w_wr_state_next = W_RESP;
      W_RESP: if (S_AXI_BREADY) w_wr_state_next = W_IDLE;
      default:                  w_wr_state_next = W_IDLE;
    endcase
  end

  always_comb begin
    w_cfg_next = apply_wstrb(r_cfg[r_aw_idx[1:0]], r_wdata, r_wstrb);
    // The clear bit is a command, never stored.
    if (r_aw_idx == REG_CFG0) w_cfg_next[CTRL_CLR_BIT] = 1'b0;
  end

  // NOTE: the four config words are individual flops feeding the datapath,
  // so they are reset like any other register rather than left as RAM.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      for (int i = 0; i < 4; i++) r_cfg[i] <= '0;
    end else if (w_commit && !r_aw_idx[2]) begin
      r_cfg[r_aw_idx[1:0]] <= w_cfg_next;
    end
  end

  assign S_AXI_BVALID = (r_wr_state == W_RESP);
  assign S_AXI_BRESP  = AXI_RESP_OKAY;
  assign cfg_reg0     = r_cfg[0];
  assign cfg_reg1     = r_cfg[1];
  assign cfg_reg2     = r_cfg[2];
  assign cfg_reg3     = r_cfg[3];

  // ---------------- sample capture ----------------
  logic [31:0] w_sample, w_count;

  adc_sample_capture #(.ADC_WIDTH(C_ADC_WIDTH)) u_capture (
    .clk      (ACLK),
    .rst_n    (ARESETN),
    .i_en     (r_cfg[0][CTRL_EN_BIT]),
    .i_clr    (w_clr),
    .i_valid  (adc_valid),
    .i_data   (adc_data),
    .o_sample (w_sample),
    .o_count  (w_count)
  );

  // ---------------- read channel ----------------
  rd_state_t                     r_rd_state, w_rd_state_next;
  logic                          r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0] r_rdata;
  logic [31:0]                   w_rd_mux;
  logic                          w_ar_hs;

  assign S_AXI_ARREADY = ARESETN && S_AXI_ARVALID && (r_rd_state == R_IDLE);
  assign w_ar_hs       = S_AXI_ARVALID && S_AXI_ARREADY;

  always_comb begin
    w_rd_mux = '0;
    case (S_AXI_ARADDR[4:2])
      REG_CFG0:   w_rd_mux = r_cfg[0];
      REG_CFG1:   w_rd_mux = r_cfg[1];
      REG_CFG2:   w_rd_mux = r_cfg[2];
      REG_CFG3:   w_rd_mux = r_cfg[3];
      REG_SAMPLE: w_rd_mux = w_sample;
      REG_COUNT:  w_rd_mux = w_count;
      default:    w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_rd_state <= R_IDLE;
    else          r_rd_state <= w_rd_state_next;
  end

  always_comb begin
    w_rd_state_next = r_rd_state;
    case (r_rd_state)
      R_IDLE: if (w_ar_hs)                   w_rd_state_next = R_DATA;
      R_DATA: if (r_rvalid && S_AXI_RREADY)  w_rd_state_next = R_IDLE;
      default:                               w_rd_state_next = R_IDLE;
    endcase
  end

  // RDATA is captured at the address handshake (so a same-cycle write is not
  // yet visible) and RVALID follows one edge later.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      if (w_ar_hs) r_rdata <= w_rd_mux;
      if (r_rd_state == R_DATA && !r_rvalid) r_rvalid <= 1'b1;
      else if (r_rvalid && S_AXI_RREADY)     r_rvalid <= 1'b0;
    end
  end

  assign S_AXI_RDATA  = r_rdata;
  assign S_AXI_RVALID = r_rvalid;
  assign S_AXI_RRESP  = AXI_RESP_OKAY;

  logic w_unused_ok;
  assign w_unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule
